// File: rtl/sphere_fsm_32bit_simple_minimal.sv
// k-th low-discrepancy point on S2: VdC digits -> cos/sin phi (isqrt) -> CORDIC theta -> scale.
// Latency 1..32 VdC cycles + 34 fixed; single request in flight, ready only in IDLE, start ignored when busy.
module sphere_fsm_32bit_simple_minimal #(
    parameter int W        = 32,
    parameter int FRAC     = 16,
    parameter int CORDIC_N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] k_in,
    input  logic [1:0]   base_sel0,
    input  logic [1:0]   base_sel1,
    output logic [W-1:0] result_x,
    output logic [W-1:0] result_y,
    output logic [W-1:0] result_z,
    output logic         done,
    output logic         ready
);

    localparam logic signed [31:0] ONE        = 32'sd1 <<< FRAC;
    localparam logic signed [31:0] INV_K      = 32'sh26DD3B6A;
    localparam logic        [31:0] TWO_PI_Q29 = 32'd3373259426;
    localparam logic        [32:0] SCALE_INIT = 33'h1_0000_0000;

    typedef enum logic [2:0] {S_IDLE, S_VDC, S_SQRT, S_CORDIC, S_MUL, S_DONE} state_t;

    state_t state, state_nxt;

    logic        [31:0] n [2];
    logic        [2:0]  b [2];
    logic        [32:0] scale [2];
    logic        [31:0] acc [2];
    logic        [31:0] n_nxt [2];
    logic        [32:0] scale_nxt [2];
    logic        [31:0] acc_nxt [2];
    logic        [2:0]  r [2];
    logic               vdc_fin;
    logic        [4:0]  cnt;
    logic signed [31:0] c_q, c_new, t_new;
    logic signed [63:0] c_ext, csq;
    logic        [31:0] rad, rad_new, rem;
    logic        [33:0] rem_sh, trial;
    logic        [15:0] root;
    logic        [63:0] angp;
    logic signed [31:0] cx, cy, cz, cx_sh, cy_sh;
    logic signed [63:0] sp64, cos64, sin64;

    function automatic logic signed [31:0] atan_q30(input logic [3:0] i);
        case (i)
            4'd0:    atan_q30 = 32'sh3243F6A9;
            4'd1:    atan_q30 = 32'sh1DAC6705;
            4'd2:    atan_q30 = 32'sh0FADBAFD;
            4'd3:    atan_q30 = 32'sh07F56EA7;
            4'd4:    atan_q30 = 32'sh03FEAB77;
            4'd5:    atan_q30 = 32'sh01FFD55C;
            4'd6:    atan_q30 = 32'sh00FFFAAB;
            4'd7:    atan_q30 = 32'sh007FFF55;
            4'd8:    atan_q30 = 32'sh003FFFEB;
            4'd9:    atan_q30 = 32'sh001FFFFD;
            4'd10:   atan_q30 = 32'sh00100000;
            4'd11:   atan_q30 = 32'sh00080000;
            4'd12:   atan_q30 = 32'sh00040000;
            4'd13:   atan_q30 = 32'sh00020000;
            4'd14:   atan_q30 = 32'sh00010000;
            default: atan_q30 = 32'sh00008000;
        endcase
    endfunction

    // Product of two Q16.16 values, bits [47:16], clamped to +/-1.0
    function automatic logic [31:0] sat_q16(input logic signed [63:0] p);
        logic signed [63:0] s;
        s = p >>> FRAC;
        if (s > (64'sd1 <<< FRAC))
            sat_q16 = ONE;
        else if (s < -(64'sd1 <<< FRAC))
            sat_q16 = -ONE;
        else
            sat_q16 = 32'(s);
    endfunction

    always_comb begin
        // A finished stream has n = 0, so its digit is 0 and acc stays put
        for (int s = 0; s < 2; s++) begin
            n_nxt[s]     = n[s] / {29'd0, b[s]};
            r[s]         = 3'(n[s] % {29'd0, b[s]});
            scale_nxt[s] = scale[s] / {30'd0, b[s]};
            acc_nxt[s]   = acc[s] + 32'(scale_nxt[s] * {30'd0, r[s]});
        end
        vdc_fin = (n_nxt[0] == 32'd0) && (n_nxt[1] == 32'd0);

        c_new = 32'(acc_nxt[0] >> (31 - FRAC)) - ONE;
        c_ext = {{32{c_new[31]}}, c_new};
        csq   = c_ext * c_ext;
        t_new = ONE - 32'(csq >>> FRAC);
        if (t_new < 0)
            t_new = 32'sd0;
        // t = 1.0 would need a 33-bit radicand; clip to all-ones (sqrt -> 0xFFFF)
        rad_new = (t_new >= ONE) ? 32'hFFFF_FFFF : {t_new[15:0], 16'd0};

        rem_sh = {rem, rad[31:30]};
        trial  = {16'd0, root, 2'b01};

        angp  = 64'({2'b00, acc[1][29:0]}) * 64'(TWO_PI_Q29);
        cx_sh = cx >>> cnt;
        cy_sh = cy >>> cnt;

        sp64  = {48'd0, root};
        cos64 = 64'(cx >>> (30 - FRAC));
        sin64 = 64'(cy >>> (30 - FRAC));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_VDC;
            S_VDC:    if (vdc_fin) state_nxt = S_SQRT;
            S_SQRT:   if (cnt == 5'd15) state_nxt = S_CORDIC;
            S_CORDIC: if (cnt == 5'(CORDIC_N - 1)) state_nxt = S_MUL;
            S_MUL:    state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        ready = (state == S_IDLE);
        done  = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                n[s]     <= '0;
                b[s]     <= 3'd2;
                scale[s] <= '0;
                acc[s]   <= '0;
            end
            cnt      <= '0;
            c_q      <= '0;
            rad      <= '0;
            rem      <= '0;
            root     <= '0;
            cx       <= '0;
            cy       <= '0;
            cz       <= '0;
            result_x <= '0;
            result_y <= '0;
            result_z <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    n[0]     <= k_in;
                    n[1]     <= k_in;
                    b[0]     <= {1'b0, base_sel0} + 3'd2;
                    b[1]     <= {1'b0, base_sel1} + 3'd2;
                    scale[0] <= SCALE_INIT;
                    scale[1] <= SCALE_INIT;
                    acc[0]   <= '0;
                    acc[1]   <= '0;
                end
                S_VDC: begin
                    for (int s = 0; s < 2; s++) begin
                        n[s]     <= n_nxt[s];
                        scale[s] <= scale_nxt[s];
                        acc[s]   <= acc_nxt[s];
                    end
                    if (vdc_fin) begin
                        c_q  <= c_new;
                        rad  <= rad_new;
                        rem  <= '0;
                        root <= '0;
                        cnt  <= '0;
                    end
                end
                S_SQRT: begin
                    rad <= rad << 2;
                    if (rem_sh >= trial) begin
                        rem  <= 32'(rem_sh - trial);
                        root <= {root[14:0], 1'b1};
                    end else begin
                        rem  <= 32'(rem_sh);
                        root <= {root[14:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        cnt <= '0;
                        // Quadrant of theta picks the start vector; residual angle < pi/2 in Q2.30
                        case (acc[1][31:30])
                            2'd0:    begin cx <= INV_K;  cy <= '0;     end
                            2'd1:    begin cx <= '0;     cy <= INV_K;  end
                            2'd2:    begin cx <= -INV_K; cy <= '0;     end
                            default: begin cx <= '0;     cy <= -INV_K; end
                        endcase
                        cz <= 32'(angp >> 31);
                    end
                end
                S_CORDIC: begin
                    if (cz >= 0) begin
                        cx <= cx - cy_sh;
                        cy <= cy + cx_sh;
                        cz <= cz - atan_q30(cnt[3:0]);
                    end else begin
                        cx <= cx + cy_sh;
                        cy <= cy - cx_sh;
                        cz <= cz + atan_q30(cnt[3:0]);
                    end
                    cnt <= cnt + 5'd1;
                end
                S_MUL: begin
                    result_x <= sat_q16(sp64 * cos64);
                    result_y <= sat_q16(sp64 * sin64);
                    result_z <= c_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sphere_fsm_32bit_simple_minimal.sv
// Directed bench for sphere_fsm_32bit_simple_minimal: hand-computed points, handshake and reset cases.
module tb_sphere_fsm_32bit_simple_minimal;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] k_in;
    logic [1:0]  base_sel0, base_sel1;
    logic [31:0] result_x, result_y, result_z;
    logic        done, ready;

    int          checks = 0;
    int          failures = 0;
    int          lat, lat1, lat2, lat_big, ndone;
    logic [31:0] rx, ry, rz;

    sphere_fsm_32bit_simple_minimal dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_in(k_in),
        .base_sel0(base_sel0), .base_sel1(base_sel1),
        .result_x(result_x), .result_y(result_y), .result_z(result_z),
        .done(done), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol);
        logic [31:0] d;
        checks++;
        d = got - exp;
        if (d[31]) d = -d;
        if (d > 32'(tol)) begin
            failures++;
            $display("FAIL %s got=0x%08h want=0x%08h tol=%0d", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] k, input logic [1:0] s0, input logic [1:0] s1, output int l);
        k_in = k; base_sel0 = s0; base_sel1 = s1; start = 1'b1;
        tick();
        start = 1'b0;
        check("ready_drop", 32'(ready), 32'd0, 0);
        l = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done) begin
                l = i;
                break;
            end
        end
        check("done_seen", 32'(l != 0), 32'd1, 0);
        check("lat_max72", 32'(l <= 72), 32'd1, 0);
        rx = result_x; ry = result_y; rz = result_z;
        tick();
        check("done_1cyc", 32'(done), 32'd0, 0);
        check("ready_after", 32'(ready), 32'd1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; k_in = '0; base_sel0 = '0; base_sel1 = '0;
        repeat (3) tick();
        check("rst_x", result_x, 32'd0, 0);
        check("rst_y", result_y, 32'd0, 0);
        check("rst_z", result_z, 32'd0, 0);
        check("rst_done", 32'(done), 32'd0, 0);
        check("rst_ready", 32'(ready), 32'd1, 0);
        rst_n = 1'b1;
        tick();

        request(32'd1, 2'd0, 2'd1, lat1);
        check("k1_x", rx, 32'hFFFF8000, 16);
        check("k1_y", ry, 32'h0000DDB4, 16);
        check("k1_z", rz, 32'h00000000, 0);

        request(32'd2, 2'd0, 2'd1, lat2);
        check("k2_x", rx, 32'hFFFF9127, 16);
        check("k2_y", ry, 32'hFFFF4000, 16);
        check("k2_z", rz, 32'hFFFF8000, 0);

        request(32'd3, 2'd0, 2'd1, lat);
        check("k3_x", rx, 32'h0000A9D5, 16);
        check("k3_y", ry, 32'h00008E84, 16);
        check("k3_z", rz, 32'h00008000, 0);

        request(32'd0, 2'd2, 2'd3, lat);
        check("k0_x", rx, 32'h00000000, 16);
        check("k0_y", ry, 32'h00000000, 16);
        check("k0_z", rz, 32'hFFFF0000, 0);

        // 32 base-2 digits versus 1 digit for k=1: 31 extra VdC cycles, rest fixed
        request(32'hFFFF_FFFF, 2'd0, 2'd0, lat_big);
        check("kmax_vdc32", 32'(lat_big - lat1), 32'd31, 0);
        check("kmax_z", rz, 32'h00010000, 16);
        check("kmax_y", ry, 32'h00000000, 16);

        // start held high, inputs changed mid-run
        k_in = 32'd2; base_sel0 = 2'd0; base_sel1 = 2'd1; start = 1'b1;
        tick();
        check("held_busy", 32'(ready), 32'd0, 0);
        repeat (4) tick();
        k_in = 32'd3; base_sel0 = 2'd2; base_sel1 = 2'd2;
        lat = 0;
        for (int i = 5; i <= 100; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check("held_lat", 32'(lat), 32'(lat2), 0);
        check("held_x", result_x, 32'hFFFF9127, 16);
        check("held_y", result_y, 32'hFFFF4000, 16);
        check("held_z", result_z, 32'hFFFF8000, 0);
        ndone = 0;
        repeat (60) begin
            tick();
            if (done) ndone++;
        end
        check("held_no_restart", 32'(ndone), 32'd0, 0);

        // reset in the middle of CORDIC
        k_in = 32'd1; base_sel0 = 2'd0; base_sel1 = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (25) tick();
        rst_n = 1'b0;
        #2;
        check("midrst_x", result_x, 32'd0, 0);
        check("midrst_y", result_y, 32'd0, 0);
        check("midrst_z", result_z, 32'd0, 0);
        check("midrst_ready", 32'(ready), 32'd1, 0);
        check("midrst_done", 32'(done), 32'd0, 0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        repeat (60) begin
            tick();
            if (done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0, 0);

        request(32'd1, 2'd0, 2'd1, lat);
        check("post_rst_x", rx, 32'hFFFF8000, 16);
        check("post_rst_y", ry, 32'h0000DDB4, 16);
        check("post_rst_z", rz, 32'h00000000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
